// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: immediate-generation mode encodings.
package mips_pkg;

  localparam int IMM_MODE_W = 3;

  localparam logic [IMM_MODE_W-1:0] IMM_MODE_ZERO   = 3'd0;
  localparam logic [IMM_MODE_W-1:0] IMM_MODE_SIGN   = 3'd1;
  localparam logic [IMM_MODE_W-1:0] IMM_MODE_LUI    = 3'd2;
  localparam logic [IMM_MODE_W-1:0] IMM_MODE_BRANCH = 3'd3;
  localparam logic [IMM_MODE_W-1:0] IMM_MODE_SHAMT  = 3'd4;

  function automatic logic imm_mode_legal(input logic [IMM_MODE_W-1:0] mode);
    logic legal;
    case (mode)
      IMM_MODE_ZERO, IMM_MODE_SIGN, IMM_MODE_LUI,
      IMM_MODE_BRANCH, IMM_MODE_SHAMT: legal = 1'b1;
      default:                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Two-entry valid/ready skid buffer: an output register plus one overflow slot.
// in_ready is registered and is the complement of the overflow slot's valid bit.
module imm_skid_buf
  import mips_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         in_ready_q;
  logic         accept_s;
  logic         out_free_s;

  assign accept_s   = in_valid_i & in_ready_q;
  assign out_free_s = ~out_valid_q | out_ready_i;

  // Next-state selection; the skid slot can only be filled while the output is stalled.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free_s) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept_s) begin
        out_valid_d  = 1'b1;
        out_data_d   = in_data_i;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_i;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= {W{1'b0}};
      skid_valid_q <= 1'b0;
      skid_data_q  <= {W{1'b0}};
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= ~skid_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/imm_gen_stage.sv
// ID->EX immediate generator: combinational extension mux feeding a registered skid buffer
// that carries {err, tag, operand} together.
module imm_gen_stage
  import mips_pkg::*;
#(
  parameter int IMM_W    = 16,
  parameter int DATA_W   = 32,
  parameter int SHAMT_LO = 6,
  parameter int SHAMT_W  = 5,
  parameter int TAG_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IMM_W-1:0]      in_imm,
  input  logic [IMM_MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_err
);

  localparam int PKT_W = DATA_W + TAG_W + 1;

  logic [DATA_W-1:0]  zero_ext_s;
  logic [DATA_W-1:0]  sign_ext_s;
  logic [2*IMM_W-1:0] lui_wide_s;
  logic [DATA_W-1:0]  lui_s;
  logic [DATA_W-1:0]  branch_s;
  logic [DATA_W-1:0]  shamt_s;
  logic [DATA_W-1:0]  ext_data_s;
  logic               ext_err_s;
  logic [PKT_W-1:0]   pkt_in_s;
  logic [PKT_W-1:0]   pkt_out_s;

  assign zero_ext_s = {{(DATA_W-IMM_W){1'b0}}, in_imm};
  assign sign_ext_s = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  // LUI keeps the low DATA_W bits of {imm, zeros}, zero-filling when DATA_W is wider.
  assign lui_wide_s = {in_imm, {IMM_W{1'b0}}};
  assign lui_s      = DATA_W'(lui_wide_s);
  assign branch_s   = {sign_ext_s[DATA_W-3:0], 2'b00};
  assign shamt_s    = {{(DATA_W-SHAMT_W){1'b0}}, in_imm[SHAMT_LO+SHAMT_W-1 -: SHAMT_W]};

  // Extension mux; illegal modes fall back to zero-extension and raise err.
  always_comb begin
    ext_data_s = zero_ext_s;
    ext_err_s  = ~imm_mode_legal(in_mode);
    case (in_mode)
      IMM_MODE_ZERO:   ext_data_s = zero_ext_s;
      IMM_MODE_SIGN:   ext_data_s = sign_ext_s;
      IMM_MODE_LUI:    ext_data_s = lui_s;
      IMM_MODE_BRANCH: ext_data_s = branch_s;
      IMM_MODE_SHAMT:  ext_data_s = shamt_s;
      default:         ext_data_s = zero_ext_s;
    endcase
  end

  assign pkt_in_s = {ext_err_s, in_tag, ext_data_s};

  imm_skid_buf #(
    .W (PKT_W)
  ) u_skid (
    .clk_i       (clk),
    .rst_i       (reset),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (pkt_in_s),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (pkt_out_s)
  );

  assign out_err  = pkt_out_s[PKT_W-1];
  assign out_tag  = pkt_out_s[DATA_W+TAG_W-1:DATA_W];
  assign out_data = pkt_out_s[DATA_W-1:0];

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: vector table for extension modes, hand sequences
// for backpressure, streaming, flush and asynchronous reset.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_mode;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_tag;
  logic        out_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imm_gen_stage dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  typedef struct {
    logic [15:0] imm;
    logic [2:0]  mode;
    logic [7:0]  tag;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] tag);
    in_valid = 1'b1;
    in_imm   = {8'h00, tag};
    in_mode  = 3'd0;
    in_tag   = tag;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [2:0] mode);
    case (mode)
      3'd0:    return {16'h0000, imm};
      3'd1:    return {{16{imm[15]}}, imm};
      3'd2:    return {imm, 16'h0000};
      3'd3:    return {{14{imm[15]}}, imm, 2'b00};
      3'd4:    return {27'd0, imm[10:6]};
      default: return {16'h0000, imm};
    endcase
  endfunction

  initial begin
    vecs[0]  = '{16'h8001, 3'd1, 8'h10, 32'hFFFF8001, 1'b0};
    vecs[1]  = '{16'h8001, 3'd0, 8'h11, 32'h00008001, 1'b0};
    vecs[2]  = '{16'h8001, 3'd2, 8'h12, 32'h80010000, 1'b0};
    vecs[3]  = '{16'hFFFF, 3'd3, 8'h13, 32'hFFFFFFFC, 1'b0};
    vecs[4]  = '{16'h07C0, 3'd4, 8'h14, 32'h0000001F, 1'b0};
    vecs[5]  = '{16'h1234, 3'd6, 8'h15, 32'h00001234, 1'b1};
    vecs[6]  = '{16'h7FFF, 3'd1, 8'h16, 32'h00007FFF, 1'b0};
    vecs[7]  = '{16'h0001, 3'd3, 8'h17, 32'h00000004, 1'b0};
    vecs[8]  = '{16'hF83F, 3'd4, 8'h18, 32'h00000000, 1'b0};
    vecs[9]  = '{16'hFFFF, 3'd7, 8'h19, 32'h0000FFFF, 1'b1};
    vecs[10] = '{16'hABCD, 3'd5, 8'h1A, 32'h0000ABCD, 1'b1};
    vecs[11] = '{16'hFFFF, 3'd2, 8'hFF, 32'hFFFF0000, 1'b0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = 16'h0000;
    in_mode = 3'd0; in_tag = 8'h00; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", {24'd0, out_tag}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    reset = 1'b0;
    step();

    // Extension table, one cycle latency each, output always ready.
    for (int i = 0; i < 12; i++) begin
      in_imm = vecs[i].imm; in_mode = vecs[i].mode; in_tag = vecs[i].tag; in_valid = 1'b1;
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_tag", i), {24'd0, out_tag}, {24'd0, vecs[i].tag});
      chk($sformatf("vec%0d_err", i), {31'd0, out_err}, {31'd0, vecs[i].exp_err});
    end
    step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: two pushes fill output and skid, then drain in order.
    out_ready = 1'b0;
    push(8'd1);
    chk("bp_ready_after1", {31'd0, in_ready}, 32'd1);
    push(8'd2);
    chk("bp_ready_after2", {31'd0, in_ready}, 32'd0);
    chk("bp_head_tag", {24'd0, out_tag}, 32'd1);
    step();
    chk("bp_hold_tag", {24'd0, out_tag}, 32'd1);
    chk("bp_hold_data", out_data, 32'd1);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_pop2_tag", {24'd0, out_tag}, 32'd2);
    chk("bp_pop2_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_ready_rise", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Streaming: one operand per cycle, in order.
    for (int i = 0; i < 100; i++) begin
      in_imm = 16'($urandom); in_mode = 3'($urandom_range(0, 7)); in_tag = 8'(i);
      in_valid = 1'b1;
      step();
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_data", out_data, ref_ext(in_imm, in_mode));
      chk("stream_tag", {24'd0, out_tag}, {24'd0, in_tag});
      chk("stream_err", {31'd0, out_err}, {31'd0, (in_mode > 3'd4)});
      chk("stream_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_end", {31'd0, out_valid}, 32'd0);

    // Flush with skid full and a pending input.
    out_ready = 1'b0;
    push(8'hA1);
    push(8'hA2);
    in_valid = 1'b1; in_tag = 8'hA3; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_leak", {31'd0, out_valid}, 32'd0);
    end

    // Flush coinciding with an accept into a free skid slot.
    out_ready = 1'b0;
    push(8'hB1);
    in_valid = 1'b1; in_tag = 8'hB2; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_acc_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_acc_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("flush_acc_no_leak", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset between edges while stalled with the skid full.
    out_ready = 1'b0;
    push(8'hC1);
    push(8'hC2);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_valid", {31'd0, out_valid}, 32'd0);
    chk("areset_data", out_data, 32'd0);
    chk("areset_tag", {24'd0, out_tag}, 32'd0);
    chk("areset_ready", {31'd0, in_ready}, 32'd1);
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_imm = 16'h8000; in_mode = 3'd1; in_tag = 8'hC5;
    step();
    in_valid = 1'b0;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_data", out_data, 32'hFFFF8000);
    chk("post_rst_tag", {24'd0, out_tag}, 32'h000000C5);
    step();
    chk("post_rst_drain", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
